// File: rtl/accum_pkg.sv
// Shared encodings for the block accumulator: accumulate modes and FSM states.
package accum_pkg;

  typedef enum logic [1:0] {
    MODE_WRAP_ADD = 2'b00,
    MODE_SAT_ADD  = 2'b01,
    MODE_WRAP_SUB = 2'b10,
    MODE_SAT_SUB  = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    HOLD = 2'b10
  } state_e;

endpackage

// File: rtl/param_adder.sv
// WIDTH-bit unsigned adder with carry out; purely combinational.
module param_adder #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out
);

  assign {carry_out, sum} = {1'b0, a} + {1'b0, b};

endmodule

// File: rtl/param_accumulator.sv
// Block accumulator: folds each accepted (a+b) into a wide accumulator with
// wrap/saturating add/sub, counts beats to a latched block length, then holds
// the result on a valid/ready output until the consumer takes it.
module param_accumulator #(
  parameter int WIDTH = 4,
  parameter int ACC_W = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic [CNT_W-1:0] block_len,
  input  logic [1:0]       mode,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic [ACC_W-1:0] acc,
  output logic [CNT_W-1:0] count,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             ovf
);

  import accum_pkg::*;

  // The pair sum must fit in the accumulator including its carry bit.
  if (ACC_W < WIDTH + 1) begin : g_bad_acc_w
    $error("param_accumulator: ACC_W must be >= WIDTH+1");
  end

  state_e           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             co_q, co_d;
  logic [CNT_W-1:0] len_q, len_d;
  mode_e            mode_q, mode_d;

  logic [WIDTH-1:0] add_sum;
  logic             add_co;
  logic [ACC_W-1:0] ps_ext;
  logic [ACC_W:0]   add_ext, sub_ext;
  logic [ACC_W-1:0] upd_acc;
  logic             upd_ovf;
  logic [CNT_W-1:0] eff_len, cnt_inc;
  mode_e            cur_mode;
  logic             accept;

  param_adder #(.WIDTH(WIDTH)) u_adder (
    .a         (a),
    .b         (b),
    .sum       (add_sum),
    .carry_out (add_co)
  );

  assign ps_ext   = ACC_W'({add_co, add_sum});
  assign add_ext  = {1'b0, acc_q} + {1'b0, ps_ext};
  assign sub_ext  = {1'b0, acc_q} - {1'b0, ps_ext};
  assign eff_len  = (block_len == '0) ? CNT_W'(1) : block_len;
  assign cnt_inc  = cnt_q + CNT_W'(1);
  // Length/mode come straight from the inputs on the first beat, latched after.
  assign cur_mode = (state_q == IDLE) ? mode_e'(mode) : mode_q;
  assign accept   = in_valid && in_ready;

  // Accumulate step for the current mode; MSB of the extended result is carry/borrow.
  always_comb begin
    upd_acc = add_ext[ACC_W-1:0];
    upd_ovf = add_ext[ACC_W];
    case (cur_mode)
      MODE_WRAP_ADD: begin
        upd_acc = add_ext[ACC_W-1:0];
        upd_ovf = add_ext[ACC_W];
      end
      MODE_SAT_ADD: begin
        upd_ovf = add_ext[ACC_W];
        upd_acc = add_ext[ACC_W] ? '1 : add_ext[ACC_W-1:0];
      end
      MODE_WRAP_SUB: begin
        upd_acc = sub_ext[ACC_W-1:0];
        upd_ovf = sub_ext[ACC_W];
      end
      MODE_SAT_SUB: begin
        upd_ovf = sub_ext[ACC_W];
        upd_acc = sub_ext[ACC_W] ? '0 : sub_ext[ACC_W-1:0];
      end
      default: ;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic; clear overrides everything and HOLD exits only on out_ready.
  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (accept) state_d = (eff_len == CNT_W'(1)) ? HOLD : RUN;
        RUN:     if (accept && (cnt_inc == len_q)) state_d = HOLD;
        HOLD:    if (out_ready) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Handshake outputs; in_ready is masked by clear so a cleared cycle takes no beat.
  always_comb begin
    in_ready  = (state_q != HOLD) && !clear;
    out_valid = (state_q == HOLD);
  end

  // Datapath next values: accumulate on beats, freeze in HOLD, zero on exit or clear.
  always_comb begin
    acc_d  = acc_q;
    cnt_d  = cnt_q;
    ovf_d  = ovf_q;
    len_d  = len_q;
    mode_d = mode_q;
    sum_d  = sum_q;
    co_d   = co_q;
    if (accept) begin
      sum_d = add_sum;
      co_d  = add_co;
    end
    if (clear) begin
      acc_d = '0;
      cnt_d = '0;
      ovf_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: if (accept) begin
          acc_d  = upd_acc;
          ovf_d  = upd_ovf;
          cnt_d  = CNT_W'(1);
          len_d  = eff_len;
          mode_d = mode_e'(mode);
        end
        RUN: if (accept) begin
          acc_d = upd_acc;
          ovf_d = ovf_q | upd_ovf;
          cnt_d = cnt_inc;
        end
        HOLD: if (out_ready) begin
          acc_d = '0;
          cnt_d = '0;
          ovf_d = 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_q  <= '0;
      cnt_q  <= '0;
      ovf_q  <= 1'b0;
      len_q  <= CNT_W'(1);
      mode_q <= MODE_WRAP_ADD;
      sum_q  <= '0;
      co_q   <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      cnt_q  <= cnt_d;
      ovf_q  <= ovf_d;
      len_q  <= len_d;
      mode_q <= mode_d;
      sum_q  <= sum_d;
      co_q   <= co_d;
    end
  end

  assign acc       = acc_q;
  assign count     = cnt_q;
  assign ovf       = ovf_q;
  assign sum       = sum_q;
  assign carry_out = co_q;

endmodule

// File: tb/tb_param_accumulator.sv
// Directed bench for param_accumulator with hand-computed expectations.
module tb_param_accumulator;

  localparam int WIDTH = 4;
  localparam int ACC_W = 8;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             clear;
  logic [CNT_W-1:0] block_len;
  logic [1:0]       mode;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a, b;
  logic [WIDTH-1:0] sum;
  logic             carry_out;
  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] count;
  logic             out_valid;
  logic             out_ready;
  logic             ovf;

  int passed = 0;
  int total  = 0;

  param_accumulator #(.WIDTH(WIDTH), .ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset_n(reset_n), .clear(clear), .block_len(block_len),
    .mode(mode), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .sum(sum), .carry_out(carry_out), .acc(acc), .count(count),
    .out_valid(out_valid), .out_ready(out_ready), .ovf(ovf)
  );

  always #5 clk = ~clk;

  // One beat offered for one cycle; sampled 1 time unit after the edge.
  task automatic send_beat(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv);
    a = av; b = bv; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic take_result();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; clear = 1'b0; block_len = '0; mode = 2'b00;
    in_valid = 1'b0; a = '0; b = '0; out_ready = 1'b0;
    #12;
    total++; if (acc !== 8'd0 || count !== 4'd0 || ovf !== 1'b0) $display("FAIL reset_acc: acc=%0d count=%0d ovf=%0b want 0/0/0", acc, count, ovf); else passed++;
    total++; if (sum !== 4'd0 || carry_out !== 1'b0) $display("FAIL reset_sum: sum=%0d co=%0b want 0/0", sum, carry_out); else passed++;
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) $display("FAIL reset_hs: out_valid=%0b in_ready=%0b want 0/1", out_valid, in_ready); else passed++;
    @(negedge clk); reset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_wrap_add();
    block_len = 4'd3; mode = 2'b00;
    send_beat(4'd1, 4'd2);
    total++; if (acc !== 8'd3 || count !== 4'd1 || out_valid !== 1'b0) $display("FAIL wrap_beat1: acc=%0d count=%0d ov=%0b want 3/1/0", acc, count, out_valid); else passed++;
    // Changes mid-block must be ignored.
    mode = 2'b11; block_len = 4'd1;
    send_beat(4'd4, 4'd5);
    total++; if (acc !== 8'd12 || count !== 4'd2 || out_valid !== 1'b0) $display("FAIL wrap_beat2: acc=%0d count=%0d ov=%0b want 12/2/0", acc, count, out_valid); else passed++;
    send_beat(4'd3, 4'd1);
    total++; if (acc !== 8'd16 || count !== 4'd3 || ovf !== 1'b0) $display("FAIL wrap_final: acc=%0d count=%0d ovf=%0b want 16/3/0", acc, count, ovf); else passed++;
    total++; if (sum !== 4'd4 || carry_out !== 1'b0) $display("FAIL wrap_sum: sum=%0d co=%0b want 4/0", sum, carry_out); else passed++;
    total++; if (out_valid !== 1'b1 || in_ready !== 1'b0) $display("FAIL wrap_hold: out_valid=%0b in_ready=%0b want 1/0", out_valid, in_ready); else passed++;
    take_result();
    total++; if (out_valid !== 1'b0 || acc !== 8'd0 || count !== 4'd0 || in_ready !== 1'b1) $display("FAIL wrap_release: ov=%0b acc=%0d count=%0d ir=%0b want 0/0/0/1", out_valid, acc, count, in_ready); else passed++;
  endtask

  task automatic test_carry();
    block_len = 4'd1; mode = 2'b00;
    send_beat(4'd15, 4'd1);
    total++; if (sum !== 4'd0 || carry_out !== 1'b1 || acc !== 8'd16) $display("FAIL carry: sum=%0d co=%0b acc=%0d want 0/1/16", sum, carry_out, acc); else passed++;
    total++; if (out_valid !== 1'b1 || count !== 4'd1) $display("FAIL carry_hold: ov=%0b count=%0d want 1/1", out_valid, count); else passed++;
    take_result();
    // block_len 0 behaves as 1
    block_len = 4'd0;
    send_beat(4'd1, 4'd1);
    total++; if (out_valid !== 1'b1 || count !== 4'd1 || acc !== 8'd2) $display("FAIL len_zero: ov=%0b count=%0d acc=%0d want 1/1/2", out_valid, count, acc); else passed++;
    take_result();
  endtask

  task automatic test_overflow(input logic [1:0] m, input logic [ACC_W-1:0] exp_acc);
    block_len = 4'd10; mode = m;
    a = 4'd15; b = 4'd15; in_valid = 1'b1;
    repeat (10) @(posedge clk);
    #1; in_valid = 1'b0;
    total++; if (acc !== exp_acc || ovf !== 1'b1) $display("FAIL overflow_m%0d: acc=%0d ovf=%0b want %0d/1", m, acc, ovf, exp_acc); else passed++;
    total++; if (count !== 4'd10 || out_valid !== 1'b1) $display("FAIL overflow_cnt_m%0d: count=%0d ov=%0b want 10/1", m, count, out_valid); else passed++;
    take_result();
    total++; if (ovf !== 1'b0) $display("FAIL overflow_clr_m%0d: ovf=%0b want 0", m, ovf); else passed++;
  endtask

  task automatic test_subtract(input logic [1:0] m, input logic [ACC_W-1:0] exp_acc);
    block_len = 4'd1; mode = m;
    send_beat(4'd2, 4'd3);
    total++; if (acc !== exp_acc || ovf !== 1'b1 || out_valid !== 1'b1) $display("FAIL sub_m%0d: acc=%0d ovf=%0b ov=%0b want %0d/1/1", m, acc, ovf, out_valid, exp_acc); else passed++;
    take_result();
  endtask

  task automatic test_backpressure();
    block_len = 4'd1; mode = 2'b00;
    send_beat(4'd2, 4'd2);
    a = 4'd7; b = 4'd7; in_valid = 1'b1; out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      total++; if (in_ready !== 1'b0 || out_valid !== 1'b1 || acc !== 8'd4 || sum !== 4'd4) $display("FAIL bp_hold%0d: ir=%0b ov=%0b acc=%0d sum=%0d want 0/1/4/4", i, in_ready, out_valid, acc, sum); else passed++;
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    total++; if (out_valid !== 1'b0 || acc !== 8'd0 || count !== 4'd0 || in_ready !== 1'b1 || sum !== 4'd4) $display("FAIL bp_release: ov=%0b acc=%0d count=%0d ir=%0b sum=%0d want 0/0/0/1/4", out_valid, acc, count, in_ready, sum); else passed++;
    @(posedge clk); #1;
    in_valid = 1'b0;
    total++; if (acc !== 8'd14 || sum !== 4'd14 || out_valid !== 1'b1) $display("FAIL bp_next: acc=%0d sum=%0d ov=%0b want 14/14/1", acc, sum, out_valid); else passed++;
    take_result();
  endtask

  task automatic test_clear();
    block_len = 4'd4; mode = 2'b00;
    send_beat(4'd1, 4'd1);
    send_beat(4'd2, 4'd2);
    total++; if (acc !== 8'd6 || count !== 4'd2) $display("FAIL clr_pre: acc=%0d count=%0d want 6/2", acc, count); else passed++;
    clear = 1'b1; a = 4'd5; b = 4'd5; in_valid = 1'b1;
    #1;
    total++; if (in_ready !== 1'b0) $display("FAIL clr_ready: in_ready=%0b want 0", in_ready); else passed++;
    @(posedge clk); #1;
    clear = 1'b0; in_valid = 1'b0;
    total++; if (acc !== 8'd0 || count !== 4'd0 || out_valid !== 1'b0 || ovf !== 1'b0 || sum !== 4'd4) $display("FAIL clr_post: acc=%0d count=%0d ov=%0b ovf=%0b sum=%0d want 0/0/0/0/4", acc, count, out_valid, ovf, sum); else passed++;
    block_len = 4'd1;
    send_beat(4'd3, 4'd3);
    total++; if (acc !== 8'd6 || count !== 4'd1 || out_valid !== 1'b1) $display("FAIL clr_fresh: acc=%0d count=%0d ov=%0b want 6/1/1", acc, count, out_valid); else passed++;
    take_result();
  endtask

  task automatic test_reset_mid();
    block_len = 4'd4; mode = 2'b00;
    send_beat(4'd1, 4'd1);
    send_beat(4'd2, 4'd2);
    #2 reset_n = 1'b0;
    #1;
    total++; if (acc !== 8'd0 || count !== 4'd0 || sum !== 4'd0 || carry_out !== 1'b0 || ovf !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1) $display("FAIL rst_mid: acc=%0d count=%0d sum=%0d co=%0b ovf=%0b ov=%0b ir=%0b want reset values", acc, count, sum, carry_out, ovf, out_valid, in_ready); else passed++;
    @(negedge clk); reset_n = 1'b1;
    @(posedge clk); #1;
    block_len = 4'd1;
    send_beat(4'd1, 4'd2);
    total++; if (acc !== 8'd3 || out_valid !== 1'b1) $display("FAIL rst_fresh: acc=%0d ov=%0b want 3/1", acc, out_valid); else passed++;
    take_result();
  endtask

  initial begin
    test_reset();
    test_wrap_add();
    test_carry();
    test_overflow(2'b00, 8'd44);
    test_overflow(2'b01, 8'd255);
    test_subtract(2'b10, 8'd251);
    test_subtract(2'b11, 8'd0);
    test_backpressure();
    test_clear();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
